pc_fetch_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch for the single-issue MIPS datapath.
- Issues fetch requests to instruction memory and holds each returned instruction until decode accepts it.
- Applies redirects: branch, J-type jump target {(PC+4)[31:28], instr_index, 2'b00}, and jump-register.
- Sits between the instruction memory port and the decode stage; it replaces the free-running PC+4 / jump-combine path.

---
 rtl/pc_seq_pkg.sv | 7 +
 rtl/next_pc_calc.sv | 16 +
 rtl/pc_fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state/redirect encodings and default vectors for the fetch sequencer.
package pc_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;
    typedef enum logic [1:0] {RD_BRANCH, RD_JUMP, RD_JR, RD_NONE} redir_t;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational redirect target for branch, J-type jump and jump-register.
module next_pc_calc import pc_seq_pkg::*; (
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_pc,
    input  logic [15:0] redir_imm,
    input  logic [25:0] redir_index,
    input  logic [31:0] redir_reg,
    output logic [31:0] target
);
    logic [31:0] seq;
    assign seq = redir_pc + 32'd4;
    always_comb
        target = redir_type == RD_BRANCH ? seq + {{14{redir_imm[15]}}, redir_imm, 2'b00} :
                 redir_type == RD_JUMP   ? {seq[31:28], redir_index, 2'b00} :
                                           redir_reg & 32'hFFFF_FFFC;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, issues instruction fetches and holds each instruction for decode.
// Optional exception entry (exc_req/epc) is enabled by defining PC_SEQ_EXCEPTION_EN.
module pc_fetch_sequencer import pc_seq_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
`ifdef PC_SEQ_EXCEPTION_EN
    , parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [31:0] redir_pc,
    input  logic [15:0] redir_imm,
    input  logic [25:0] redir_index,
    input  logic [31:0] redir_reg
`ifdef PC_SEQ_EXCEPTION_EN
    , input  logic        exc_req
    , output logic [31:0] epc
`endif
);
    state_t      state, state_n;
    logic [31:0] pc, pc_n, fa, fa_n, instr_n, instr_pc_n, target, calc_target;
    logic        valid_n, take;

    next_pc_calc u_calc (
        .redir_type (redir_type),
        .redir_pc   (redir_pc),
        .redir_imm  (redir_imm),
        .redir_index(redir_index),
        .redir_reg  (redir_reg),
        .target     (calc_target)
    );

`ifdef PC_SEQ_EXCEPTION_EN
    logic [31:0] epc_n;
    assign take   = exc_req | (redir_valid && redir_type != RD_NONE);
    assign target = exc_req ? EXC_VECTOR : calc_target;
    always_comb begin
        epc_n = epc;
        if (exc_req) epc_n = state == S_HOLD ? instr_pc : fa;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) epc <= '0;
        else epc <= epc_n;
`else
    assign take   = redir_valid && redir_type != RD_NONE;
    assign target = calc_target;
`endif

    assign imem_req  = state == S_FETCH || state == S_DRAIN;
    assign imem_addr = fa;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fa_n       = fa;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;
        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
                if (take) begin
                    pc_n = target;
                    fa_n = target;
                end
            end
            S_FETCH:
                if (take) begin
                    // without an ack the old request is still in flight, so fa must stay put
                    pc_n    = target;
                    fa_n    = imem_ack ? target : fa;
                    state_n = imem_ack ? S_FETCH : S_DRAIN;
                end else if (imem_ack) begin
                    instr_n    = imem_rdata;
                    instr_pc_n = fa;
                    valid_n    = 1'b1;
                    pc_n       = fa + 32'd4;
                    state_n    = S_HOLD;
                end
            S_DRAIN: begin
                pc_n = take ? target : pc;
                if (imem_ack) begin
                    fa_n    = pc_n;
                    state_n = S_FETCH;
                end
            end
            S_HOLD:
                if (take) begin
                    valid_n = 1'b0;
                    pc_n    = target;
                    fa_n    = target;
                    state_n = S_FETCH;
                end else if (instr_ready) begin
                    valid_n = 1'b0;
                    fa_n    = pc;
                    state_n = S_FETCH;
                end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_VECTOR;
            fa          <= RESET_VECTOR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fa          <= fa_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
        end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed corner cases, a redirect-target table, and a randomized run
// checked against a transaction-level model of the delivered instruction stream.
module tb_pc_fetch_sequencer;
    logic        clk = 0, reset = 1;
    logic        imem_req, imem_ack = 0, instr_valid, instr_ready = 1, redir_valid = 0;
    logic [31:0] imem_addr, imem_rdata = 0, instr, instr_pc, redir_pc = 0, redir_reg = 0;
    logic [1:0]  redir_type = 0;
    logic [15:0] redir_imm = 0;
    logic [25:0] redir_index = 0;
`ifdef PC_SEQ_EXCEPTION_EN
    logic        exc_req = 0;
    logic [31:0] epc;
`endif
    int checks = 0, errors = 0;

    pc_fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_index(redir_index), .redir_reg(redir_reg)
`ifdef PC_SEQ_EXCEPTION_EN
        , .exc_req(exc_req), .epc(epc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] p;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] r;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[8];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [31:0] p,
                                               input logic [15:0] imm, input logic [25:0] idx,
                                               input logic [31:0] r);
        int off;
        off = $signed(imm);
        if (t == 2'd0) return p + 32'd4 + 32'(off * 4);
        if (t == 2'd1) return ((p + 32'd4) & 32'hF000_0000) | ({6'd0, idx} << 2);
        return r & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input int lat, input logic [31:0] a);
        wait_req("fetch_req");
        chk("fetch_addr", imem_addr, a);
        repeat (lat) begin
            tick();
            chk("addr_stable", imem_addr, a);
        end
        imem_ack = 1;
        imem_rdata = mem(a);
        tick();
        imem_ack = 0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        chk("instr_pc", instr_pc, a);
        chk("instr", instr, mem(a));
    endtask

    task automatic set_redir(input logic [1:0] t, input logic [31:0] p, input logic [15:0] imm,
                             input logic [25:0] idx, input logic [31:0] r);
        redir_valid = 1;
        redir_type = t;
        redir_pc = p;
        redir_imm = imm;
        redir_index = idx;
        redir_reg = r;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int wc, accepts;
        tab[0] = '{2'd0, 32'h0000_1000, 16'h0010, 26'd0, 32'd0, 32'h0000_1044};
        tab[1] = '{2'd0, 32'h0000_0000, 16'h8000, 26'd0, 32'd0, 32'hFFFE_0004};
        tab[2] = '{2'd0, 32'hFFFF_FFFC, 16'h0000, 26'd0, 32'd0, 32'h0000_0000};
        tab[3] = '{2'd1, 32'hA000_0000, 16'h0000, 26'h3FF_FFFF, 32'd0, 32'hAFFF_FFFC};
        tab[4] = '{2'd1, 32'hEFFF_FFFC, 16'h0000, 26'd1, 32'd0, 32'hF000_0004};
        tab[5] = '{2'd2, 32'h0000_0000, 16'h0000, 26'd0, 32'h1234_5677, 32'h1234_5674};
        tab[6] = '{2'd3, 32'h0000_0000, 16'h0004, 26'd5, 32'h0000_0040, 32'h1234_5678};
        tab[7] = '{2'd0, 32'h0040_0000, 16'hFFFF, 26'd0, 32'd0, 32'h0040_0000};

        // reset values
        repeat (2) tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'h0040_0000);
        reset = 0;

        // sequential fetch with ready held high
        do_fetch(2, 32'h0040_0000);
        do_fetch(2, 32'h0040_0004);
        do_fetch(2, 32'h0040_0008);

        // decode stall
        instr_ready = 0;
        repeat (5) begin
            tick();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, mem(32'h0040_0008));
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1;
        tick();
        chk("accept_req", {31'd0, imem_req}, 32'd1);
        chk("accept_addr", imem_addr, 32'h0040_000C);

        // jump while fetch outstanding -> drain
        set_redir(2'd1, 32'h1040_0010, 16'd0, 26'h0000100, 32'd0);
        tick();
        redir_valid = 0;
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h0040_000C);
        imem_ack = 1;
        imem_rdata = 32'hBAD0_0001;
        tick();
        imem_ack = 0;
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("jump_addr", imem_addr, 32'h1000_0400);
        do_fetch(1, 32'h1000_0400);

        // branch coinciding with ack
        wait_req("br_req");
        chk("br_pre_addr", imem_addr, 32'h1000_0404);
        set_redir(2'd0, 32'h0040_0020, 16'hFFFE, 26'd0, 32'd0);
        imem_ack = 1;
        imem_rdata = 32'hBAD0_0002;
        tick();
        imem_ack = 0;
        redir_valid = 0;
        chk("br_valid", {31'd0, instr_valid}, 32'd0);
        chk("br_req_held", {31'd0, imem_req}, 32'd1);
        chk("br_addr", imem_addr, 32'h0040_001C);
        do_fetch(0, 32'h0040_001C);

        // jump-register in HOLD beats ready; then wrap past 0xFFFFFFFC
        set_redir(2'd2, 32'd0, 16'd0, 26'd0, 32'h0040_0103);
        tick();
        redir_valid = 0;
        chk("jr_valid", {31'd0, instr_valid}, 32'd0);
        chk("jr_addr", imem_addr, 32'h0040_0100);
        do_fetch(1, 32'h0040_0100);
        set_redir(2'd2, 32'd0, 16'd0, 26'd0, 32'hFFFF_FFFC);
        tick();
        redir_valid = 0;
        do_fetch(3, 32'hFFFF_FFFC);
        do_fetch(0, 32'h0000_0000);

        // redirect target table, applied in HOLD with ready high
        for (int i = 0; i < 8; i++) begin
            set_redir(tab[i].t, tab[i].p, tab[i].imm, tab[i].idx, tab[i].r);
            tick();
            redir_valid = 0;
            chk($sformatf("tab%0d_addr", i), imem_addr, tab[i].exp);
            do_fetch(1, tab[i].exp);
        end

        // reset mid-fetch, then a stray ack in IDLE
        tick();
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        #1 reset = 1;
        #1 chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_addr", imem_addr, 32'h0040_0000);
        tick();
        reset = 0;
        imem_ack = 1;
        imem_rdata = 32'hBAD0_0003;
        tick();
        imem_ack = 0;
        chk("stray_valid", {31'd0, instr_valid}, 32'd0);
        chk("stray_addr", imem_addr, 32'h0040_0000);
        instr_ready = 0;
        do_fetch(1, 32'h0040_0000);

`ifdef PC_SEQ_EXCEPTION_EN
        exc_req = 1;
        set_redir(2'd1, 32'h0040_0000, 16'd0, 26'd7, 32'd0);
        instr_ready = 1;
        tick();
        exc_req = 0;
        redir_valid = 0;
        chk("exc_addr", imem_addr, 32'h8000_0180);
        chk("exc_epc", epc, 32'h0040_0000);
        do_fetch(1, 32'h8000_0180);
`endif

        // randomized run against the instruction-stream model
        reset = 1;
        tick();
        reset = 0;
        exp_pc = 32'h0040_0000;
        wc = $urandom_range(0, 3);
        accepts = 0;
        for (int c = 0; c < 4000; c++) begin
            imem_ack = 0;
            imem_rdata = $urandom;
            if (imem_req) begin
                if (wc == 0) begin
                    imem_ack = 1;
                    imem_rdata = mem(imem_addr);
                    wc = $urandom_range(0, 3);
                end else wc--;
            end
            redir_valid = $urandom_range(0, 7) == 0;
            redir_type = 2'($urandom_range(0, 3));
            redir_pc = $urandom;
            redir_imm = 16'($urandom);
            redir_index = 26'($urandom);
            redir_reg = $urandom;
            instr_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (imem_req && instr_valid) chk("req_while_valid", 32'd1, 32'd0);
            if (redir_valid && redir_type != 2'd3)
                exp_pc = ref_target(redir_type, redir_pc, redir_imm, redir_index, redir_reg);
            else if (instr_valid && instr_ready) begin
                chk("rnd_instr_pc", instr_pc, exp_pc);
                chk("rnd_instr", instr, mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end
            tick();
        end
        redir_valid = 0;
        imem_ack = 0;
        chk("rnd_accept_count", {31'd0, accepts >= 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
